// File: rtl/led_panel_pkg.sv
// Shared constants for the LED panel client: parameter defaults, pixel field layout and the
// position of the half-select bit in the Avalon word address.
package led_panel_pkg;

  localparam int unsigned DefRowsLines = 4;
  localparam int unsigned DefColsLines = 6;
  localparam int unsigned DefColorBits = 8;

  // Pixel word layout: {red, green, blue}, one byte each.
  localparam int unsigned PixelWidth  = 24;
  localparam int unsigned RedOffset   = 16;
  localparam int unsigned GreenOffset = 8;
  localparam int unsigned BlueOffset  = 0;

  localparam int unsigned HalfSelBit = DefRowsLines + DefColsLines;

  // The half-select bit sits directly above the {row, col} location field.
  function automatic int unsigned half_sel_bit(input int unsigned rows, input int unsigned cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/led_frame_ram.sv
// Double-banked frame store for one panel half: one write port, one synchronous read port.
// A same-address read and write in one cycle returns the previous contents.
module led_frame_ram
  import led_panel_pkg::*;
#(
  parameter int unsigned AddrWidth = 11,
  parameter int unsigned DataWidth = PixelWidth
) (
  input  logic                 clock,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [DataWidth-1:0] rd_data
);

  localparam int unsigned Depth = 1 << AddrWidth;

  logic [DataWidth-1:0] mem [Depth];

  // No reset: frame contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/led_panel_client_avalon.sv
// Avalon-MM slave frame buffer driving one HUB75-style panel, slaved to a master's scan timing.
// Pixels go into the back bank; the front bank is read out bitplane by bitplane.
module led_panel_client_avalon
  import led_panel_pkg::*;
#(
  parameter int unsigned DISPLAY_ROWS_LINES = DefRowsLines,
  parameter int unsigned DISPLAY_COLS_LINES = DefColsLines,
  parameter int unsigned COLOR_BITS         = DefColorBits
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             ext_clock200,
  input  logic [DISPLAY_ROWS_LINES+DISPLAY_COLS_LINES:0]   s1_address,
  input  logic                                             s1_write,
  input  logic [31:0]                                      s1_writedata,
  input  logic [DISPLAY_ROWS_LINES+DISPLAY_COLS_LINES-1:0] memAddrMst,
  input  logic [$clog2(COLOR_BITS)-1:0]                    bitplaneMst,
  input  logic                                             backbufferMst,
  input  logic [DISPLAY_ROWS_LINES-1:0]                    ADDR_MST,
  input  logic                                             LATCH_MST,
  input  logic                                             CLK_LED_MST,
  input  logic                                             BLANK_MST,
  output logic [1:0]                                       led_red,
  output logic [1:0]                                       led_green,
  output logic [1:0]                                       led_blue,
  output logic [DISPLAY_ROWS_LINES-1:0]                    led_addr,
  output logic                                             led_clock,
  output logic                                             led_latch,
  output logic                                             led_blank
);

  localparam int unsigned LocBits = DISPLAY_ROWS_LINES + DISPLAY_COLS_LINES;
  localparam int unsigned BpBits  = $clog2(COLOR_BITS);
  localparam int unsigned HalfBit = half_sel_bit(DISPLAY_ROWS_LINES, DISPLAY_COLS_LINES);

  logic unused_inputs;
  assign unused_inputs = ^{ext_clock200, s1_writedata[31:PixelWidth]};

  logic [PixelWidth-1:0] rd_pixel [2];

  for (genvar h = 0; h < 2; h++) begin : g_half
    logic wr_en;
    assign wr_en = s1_write & ~reset & (s1_address[HalfBit] == 1'(h));

    led_frame_ram #(
      .AddrWidth (LocBits + 1),
      .DataWidth (PixelWidth)
    ) u_ram (
      .clock   (clock),
      .wr_en   (wr_en),
      .wr_addr ({~backbufferMst, s1_address[LocBits-1:0]}),
      .wr_data (s1_writedata[PixelWidth-1:0]),
      .rd_addr ({backbufferMst, memAddrMst}),
      .rd_data (rd_pixel[h])
    );
  end

  logic [COLOR_BITS-1:0] red_chan   [2];
  logic [COLOR_BITS-1:0] green_chan [2];
  logic [COLOR_BITS-1:0] blue_chan  [2];

  always_comb begin
    for (int h = 0; h < 2; h++) begin
      red_chan[h]   = rd_pixel[h][RedOffset +: COLOR_BITS];
      green_chan[h] = rd_pixel[h][GreenOffset +: COLOR_BITS];
      blue_chan[h]  = rd_pixel[h][BlueOffset +: COLOR_BITS];
    end
  end

  // First pipeline stage: bitplane aligned with RAM data, panel timing delayed once.
  logic [BpBits-1:0]             bitplane_q;
  logic                          rd_valid_q;
  logic [DISPLAY_ROWS_LINES-1:0] addr_q;
  logic                          latch_q;
  logic                          clk_led_q;
  logic                          blank_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bitplane_q <= '0;
      rd_valid_q <= 1'b0;
      addr_q     <= '0;
      latch_q    <= 1'b0;
      clk_led_q  <= 1'b0;
      blank_q    <= 1'b1;
      led_red    <= '0;
      led_green  <= '0;
      led_blue   <= '0;
      led_addr   <= '0;
      led_latch  <= 1'b0;
      led_clock  <= 1'b0;
      led_blank  <= 1'b1;
    end else begin
      bitplane_q <= bitplaneMst;
      rd_valid_q <= 1'b1;
      addr_q     <= ADDR_MST;
      latch_q    <= LATCH_MST;
      clk_led_q  <= CLK_LED_MST;
      blank_q    <= BLANK_MST;
      led_addr   <= addr_q;
      led_latch  <= latch_q;
      led_clock  <= clk_led_q;
      led_blank  <= blank_q;
      // RAM data read while reset was held is not shown.
      for (int h = 0; h < 2; h++) begin
        led_red[h]   <= rd_valid_q & red_chan[h][bitplane_q];
        led_green[h] <= rd_valid_q & green_chan[h][bitplane_q];
        led_blue[h]  <= rd_valid_q & blue_chan[h][bitplane_q];
      end
    end
  end

endmodule

// File: tb/tb_led_panel_client_avalon.sv
// Bench for led_panel_client_avalon: directed scenarios plus random traffic against a
// frame-array model with a two-cycle expected-output queue.
module tb_led_panel_client_avalon;

  localparam int R = 4;
  localparam int C = 6;
  localparam int B = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             ext_clock200 = 1'b0;
  logic [R+C:0]     s1_address = '0;
  logic             s1_write = 1'b0;
  logic [31:0]      s1_writedata = '0;
  logic [R+C-1:0]   memAddrMst = '0;
  logic [B-1:0]     bitplaneMst = '0;
  logic             backbufferMst = 1'b0;
  logic [R-1:0]     ADDR_MST = '0;
  logic             LATCH_MST = 1'b0;
  logic             CLK_LED_MST = 1'b0;
  logic             BLANK_MST = 1'b1;
  logic [1:0]       led_red, led_green, led_blue;
  logic [R-1:0]     led_addr;
  logic             led_clock, led_latch, led_blank;

  always #5 clock = ~clock;
  always #3 ext_clock200 = ~ext_clock200;

  led_panel_client_avalon dut (
    .clock         (clock),
    .reset         (reset),
    .ext_clock200  (ext_clock200),
    .s1_address    (s1_address),
    .s1_write      (s1_write),
    .s1_writedata  (s1_writedata),
    .memAddrMst    (memAddrMst),
    .bitplaneMst   (bitplaneMst),
    .backbufferMst (backbufferMst),
    .ADDR_MST      (ADDR_MST),
    .LATCH_MST     (LATCH_MST),
    .CLK_LED_MST   (CLK_LED_MST),
    .BLANK_MST     (BLANK_MST),
    .led_red       (led_red),
    .led_green     (led_green),
    .led_blue      (led_blue),
    .led_addr      (led_addr),
    .led_clock     (led_clock),
    .led_latch     (led_latch),
    .led_blank     (led_blank)
  );

  // Output word: {red, green, blue, addr, clock, latch, blank}; idle panel is blanked only.
  localparam logic [12:0] RstWord = 13'h0001;

  bit [23:0]   model_mem [2][2][1024];
  logic [12:0] exp_q [$];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          checking = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
  endtask

  function automatic logic [12:0] outputs_now();
    return {led_red, led_green, led_blue, led_addr, led_clock, led_latch, led_blank};
  endfunction

  // What the panel should show two cycles after the current inputs are sampled.
  function automatic logic [12:0] model_expect();
    bit [23:0] up;
    bit [23:0] lo;
    int        p;
    p  = int'(bitplaneMst);
    up = model_mem[backbufferMst][0][memAddrMst];
    lo = model_mem[backbufferMst][1][memAddrMst];
    return {lo[16+p], up[16+p], lo[8+p], up[8+p], lo[p], up[p],
            ADDR_MST, CLK_LED_MST, LATCH_MST, BLANK_MST};
  endfunction

  task automatic step();
    exp_q.push_back(model_expect());
    if (s1_write) model_mem[~backbufferMst][s1_address[10]][s1_address[9:0]] = s1_writedata[23:0];
    @(posedge clock);
    #1;
    if (exp_q.size() > 1) begin
      logic [12:0] want;
      want = exp_q.pop_front();
      if (checking) check("pipe", 32'(outputs_now()), 32'(want));
    end
  endtask

  task automatic wr(input logic bb, input logic [10:0] a, input logic [31:0] d);
    backbufferMst = bb;
    s1_write      = 1'b1;
    s1_address    = a;
    s1_writedata  = d;
    step();
    s1_write      = 1'b0;
  endtask

  initial begin
    logic [7:0]  pat;
    logic [23:0] old_px;
    pat = 8'hA5;

    // Bring-up reset, then fill both banks so every read has a known value.
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.push_back(RstWord);
    for (int bb = 1; bb >= 0; bb--) begin
      for (int a = 0; a < 2048; a++) wr(1'(bb), 11'(a), $urandom);
    end

    // Reset forces every stage regardless of inputs; writes during reset are dropped.
    reset         = 1'b1;
    BLANK_MST     = 1'b0;
    LATCH_MST     = 1'b1;
    CLK_LED_MST   = 1'b1;
    ADDR_MST      = 4'hF;
    backbufferMst = 1'b0;
    memAddrMst    = 10'h105;
    s1_write      = 1'b1;
    s1_address    = 11'h105;
    s1_writedata  = 32'hFFFF_FFFF;
    #1;
    check("rst.async", 32'(outputs_now()), 32'(RstWord));
    repeat (3) @(posedge clock);
    #1;
    check("rst.hold", 32'(outputs_now()), 32'(RstWord));
    reset       = 1'b0;
    s1_write    = 1'b0;
    LATCH_MST   = 1'b0;
    CLK_LED_MST = 1'b0;
    ADDR_MST    = '0;
    exp_q.delete();
    exp_q.push_back(RstWord);
    checking    = 1'b1;
    step();
    step();
    check("rst.blank_low", 32'(led_blank), 32'(1'b0));
    BLANK_MST = 1'b1;
    step();
    step();
    check("rst.blank_high", 32'(led_blank), 32'(1'b1));
    backbufferMst = 1'b1;
    for (int bp = 0; bp < 8; bp++) begin
      bitplaneMst = 3'(bp);
      step();
    end

    // Full red in upper half of bank 0, lower half black.
    wr(1'b1, 11'h505, 32'h0000_0000);
    wr(1'b1, 11'h105, 32'h00FF_0000);
    backbufferMst = 1'b0;
    memAddrMst    = 10'h105;
    for (int bp = 0; bp < 8; bp++) begin
      bitplaneMst = 3'(bp);
      step();
      step();
      check("red.r", 32'(led_red), 32'(2'b01));
      check("red.g", 32'(led_green), 32'(2'b00));
      check("red.b", 32'(led_blue), 32'(2'b00));
    end

    // Bitplane selection on the lower half.
    wr(1'b1, 11'h505, 32'h0000_00A5);
    backbufferMst = 1'b0;
    for (int bp = 0; bp < 8; bp++) begin
      bitplaneMst = 3'(bp);
      step();
      step();
      check("bp.b1", 32'(led_blue[1]), 32'(pat[bp]));
      check("bp.b0", 32'(led_blue[0]), 32'(1'b0));
    end

    // Back-bank writes stay invisible until the bank flips.
    wr(1'b0, 11'h105, 32'h00FF_FFFF);
    wr(1'b0, 11'h505, 32'h0000_0000);
    backbufferMst = 1'b0;
    for (int bp = 0; bp < 8; bp++) begin
      bitplaneMst = 3'(bp);
      step();
      step();
      check("iso.front_r", 32'(led_red), 32'(2'b01));
      check("iso.front_b", 32'(led_blue), 32'({pat[bp], 1'b0}));
    end
    backbufferMst = 1'b1;
    for (int bp = 0; bp < 8; bp++) begin
      bitplaneMst = 3'(bp);
      step();
      step();
      check("iso.one_half", 32'({led_red, led_green, led_blue}), 32'(6'b01_01_01));
    end
    wr(1'b0, 11'h505, 32'h00FF_FFFF);
    backbufferMst = 1'b1;
    for (int bp = 0; bp < 8; bp++) begin
      bitplaneMst = 3'(bp);
      step();
      step();
      check("iso.both", 32'({led_red, led_green, led_blue}), 32'(6'b11_11_11));
    end

    // Panel timing passes through with exactly two cycles of delay.
    for (int i = 0; i < 12; i++) begin
      int prev;
      CLK_LED_MST = i[0];
      LATCH_MST   = (i == 4);
      ADDR_MST    = (i == 4 || i == 5) ? 4'd9 : 4'd0;
      step();
      prev = i - 1;
      if (i > 0) begin
        check("ctl.clock", 32'(led_clock), 32'(prev[0]));
        check("ctl.latch", 32'(led_latch), 32'(prev == 4));
        check("ctl.addr", 32'(led_addr), (prev == 4 || prev == 5) ? 32'd9 : 32'd0);
      end
    end

    // Write and read of location 0x020 in the same cycle: old data shown, new data later.
    old_px        = model_mem[0][0][10'h020];
    memAddrMst    = 10'h020;
    bitplaneMst   = 3'd0;
    wr(1'b0, 11'h020, 32'h00FF_FFFF);
    step();
    check("coll.old", 32'(led_red[0]), 32'(old_px[16]));
    backbufferMst = 1'b1;
    step();
    step();
    check("coll.new", 32'(led_red[0]), 32'(1'b1));

    // Random traffic, half of it concentrated on a few locations so writes get displayed.
    for (int n = 0; n < 2000; n++) begin
      s1_write      = 1'($urandom_range(0, 1));
      s1_address    = 11'($urandom);
      s1_writedata  = $urandom;
      memAddrMst    = 10'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        s1_address[9:0] = 10'($urandom_range(0, 7));
        memAddrMst      = 10'($urandom_range(0, 7));
      end
      bitplaneMst   = 3'($urandom);
      if ($urandom_range(0, 7) == 0) backbufferMst = ~backbufferMst;
      ADDR_MST      = 4'($urandom);
      LATCH_MST     = 1'($urandom);
      CLK_LED_MST   = 1'($urandom);
      BLANK_MST     = 1'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
